// File: rtl/pkt_fifo_pkg.sv
// Shared types and helpers for the store-and-forward packet FIFO.
// Default geometry and write-side FSM encoding live here.
package pkt_fifo_pkg;

  localparam int unsigned DW_DEF = 8;
  localparam int unsigned AW_DEF = 15;

  typedef enum logic {
    WR,
    DROP
  } wr_state_e;

  // Pointers carry one wrap bit above the address, so differences are taken modulo 2**(aw+1).
  function automatic logic [31:0] occupancy(input logic [31:0] head,
                                            input logic [31:0] tail,
                                            input int unsigned aw);
    logic [31:0] mask;
    mask = (32'd1 << (aw + 1)) - 32'd1;
    return (head - tail) & mask;
  endfunction

endpackage

// File: rtl/pkt_fifo_sf_sdp_ram.sv
// Simple dual-port RAM for the packet FIFO: one write port, one registered read port.
// Word layout is {data, eod}; the read register resets so the egress side starts at zero.
module sdp_ram
  import pkt_fifo_pkg::*;
#(
  parameter int unsigned DW = DW_DEF,
  parameter int unsigned AW = AW_DEF
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW:0]   wdata_i,
  input  logic          re_i,
  input  logic [AW-1:0] raddr_i,
  output logic [DW:0]   rdata_o
);

  logic [DW:0] mem_q [2**AW];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rdata_o <= '0;
    end else if (re_i) begin
      rdata_o <= mem_q[raddr_i];
    end
  end

endmodule

// File: rtl/pkt_fifo_sf.sv
// Store-and-forward packet FIFO: frames become readable only once committed good at EOD.
// Define PKT_FIFO_STATS_EN to add the good_frames / dropped_frames counters.
module pkt_fifo_sf
  import pkt_fifo_pkg::*;
#(
  parameter int unsigned DW         = DW_DEF,
  parameter int unsigned AW         = AW_DEF,
  parameter int unsigned AEMPTY_CNT = 63,
  parameter int unsigned AFULL_CNT  = 31000
) (
  input  logic          clkw,
  input  logic          rst,
  input  logic [DW-1:0] di,
  input  logic          we,
  input  logic          eod_in,
  input  logic          err_in,
  // read data; the bare name is a reserved word
  output logic [DW-1:0] do_o,
  output logic          eod_out,
  input  logic          re,
  output logic          rd_valid,
  output logic          empty_flag,
  output logic          aempty_flag,
  output logic          full_flag,
  output logic          afull_flag,
  output logic [AW:0]   pkt_cnt,
  output logic          drop_pulse
`ifdef PKT_FIFO_STATS_EN
  ,
  output logic [31:0]   good_frames,
  output logic [31:0]   dropped_frames
`endif
);

  localparam int unsigned DEPTH = 2**AW;

  wr_state_e   state_q;
  logic [AW:0] wadr_q, wadr_cmt_q, radr_q;
  logic [AW:0] wadr_d, radr_d;
  logic        drop_q, rd_valid_q, aempty_q, afull_q;
  logic [AW:0] pkt_q;
  logic [31:0] occ_total, occ_cmt;
  logic        wr_acc, commit_w, drop_w, rd_acc, eod_rd_w;
  logic [DW:0] rdata;

  assign occ_total  = occupancy(32'(wadr_q), 32'(radr_q), AW);
  assign occ_cmt    = occupancy(32'(wadr_cmt_q), 32'(radr_q), AW);
  assign empty_flag = (occ_cmt == 32'd0);
  assign full_flag  = (occ_total == DEPTH);

  assign wadr_d   = wadr_q + (AW+1)'(1);
  assign radr_d   = radr_q + (AW+1)'(1);
  assign wr_acc   = (state_q == WR) & we & ~full_flag;
  assign commit_w = wr_acc & eod_in & ~err_in;
  // Both overflow and a bad EOD throw away the partial frame.
  assign drop_w   = (state_q == WR) & we & (full_flag | (eod_in & err_in));
  assign rd_acc   = re & ~empty_flag;
  assign eod_rd_w = rd_valid_q & rdata[0];

  always_ff @(posedge clkw or posedge rst) begin
    if (rst) begin
      state_q    <= WR;
      wadr_q     <= '0;
      wadr_cmt_q <= '0;
      drop_q     <= 1'b0;
    end else begin
      drop_q <= drop_w;
      case (state_q)
        WR: begin
          if (drop_w) begin
            wadr_q <= wadr_cmt_q;
            if (full_flag & ~eod_in) begin
              state_q <= DROP;
            end
          end else if (wr_acc) begin
            wadr_q <= wadr_d;
            if (commit_w) begin
              wadr_cmt_q <= wadr_d;
            end
          end
        end
        DROP: begin
          if (we & eod_in) begin
            state_q <= WR;
          end
        end
        default: state_q <= WR;
      endcase
    end
  end

  always_ff @(posedge clkw or posedge rst) begin
    if (rst) begin
      radr_q     <= '0;
      rd_valid_q <= 1'b0;
      pkt_q      <= '0;
      aempty_q   <= 1'b1;
      afull_q    <= 1'b0;
    end else begin
      if (rd_acc) begin
        radr_q <= radr_d;
      end
      rd_valid_q <= rd_acc;
      case ({commit_w, eod_rd_w})
        2'b10:   pkt_q <= pkt_q + (AW+1)'(1);
        2'b01:   pkt_q <= pkt_q - (AW+1)'(1);
        default: pkt_q <= pkt_q;
      endcase
      aempty_q <= (occ_cmt < AEMPTY_CNT);
      afull_q  <= (occ_total > AFULL_CNT);
    end
  end

  sdp_ram #(
    .DW(DW),
    .AW(AW)
  ) u_ram (
    .clk_i  (clkw),
    .rst_i  (rst),
    .we_i   (wr_acc),
    .waddr_i(wadr_q[AW-1:0]),
    .wdata_i({di, eod_in}),
    .re_i   (rd_acc),
    .raddr_i(radr_q[AW-1:0]),
    .rdata_o(rdata)
  );

  assign do_o        = rdata[DW:1];
  assign eod_out     = rdata[0];
  assign rd_valid    = rd_valid_q;
  assign aempty_flag = aempty_q;
  assign afull_flag  = afull_q;
  assign pkt_cnt     = pkt_q;
  assign drop_pulse  = drop_q;

`ifdef PKT_FIFO_STATS_EN
  logic [31:0] good_q, dropped_q;

  always_ff @(posedge clkw or posedge rst) begin
    if (rst) begin
      good_q    <= '0;
      dropped_q <= '0;
    end else begin
      if (commit_w) begin
        good_q <= good_q + 32'd1;
      end
      if (drop_w) begin
        dropped_q <= dropped_q + 32'd1;
      end
    end
  end

  assign good_frames    = good_q;
  assign dropped_frames = dropped_q;
`endif

endmodule

// File: doc/pkt_fifo_sf.md
Name: pkt_fifo_sf

Overview:
- Parametrised store-and-forward packet FIFO; successor of the single-byte EOD-tagged FIFO in the L2Switch datapath.
- Write side stores beats tagged with an end-of-frame marker; each frame is committed good or discarded at EOD.
- Read side only ever sees fully committed frames, so the egress MAC never underruns mid-frame.
- Sits between the ingress MAC/CRC checker and the switch forwarding logic; single clock domain.

Parameters:
- DW, 8, data width in bits (excluding EOD tag).
- AW, 15, address width; DEPTH = 2**AW words.
- AEMPTY_CNT, 63, committed-occupancy threshold for aempty_flag.
- AFULL_CNT, 31000, total-occupancy threshold for afull_flag.

Ports:
- clkw  in  1  sole clock, both sides.
- rst  in  1  asynchronous, active-high reset.
- di  in  DW  write data.
- we  in  1  write strobe.
- eod_in  in  1  marks last beat of a frame; qualified by we.
- err_in  in  1  with we & eod_in: frame bad, discard it.
- do  out  DW  read data.
- eod_out  out  1  EOD tag of do.
- re  in  1  read request.
- rd_valid  out  1  do/eod_out valid this cycle.
- empty_flag  out  1  no committed words.
- aempty_flag  out  1  committed occupancy < AEMPTY_CNT.
- full_flag  out  1  total occupancy == DEPTH.
- afull_flag  out  1  total occupancy > AFULL_CNT.
- pkt_cnt  out  AW+1  committed frames not yet fully read out.
- drop_pulse  out  1  one-cycle pulse per discarded frame.

Behaviour:
- Pointers, all AW+1 bits with wrap bit: wadr (speculative write), wadr_cmt (last commit), radr.
- Occupancy arithmetic is modulo 2**(AW+1). total = wadr - radr; committed = wadr_cmt - radr.
- Reset values: all pointers 0, pkt_cnt 0, rd_valid 0, drop_pulse 0, empty_flag 1, aempty_flag 1, full_flag 0, afull_flag 0, state WR, do/eod_out 0.
- Write FSM, two states:
  - WR: on we & ~full_flag, store {di, eod_in} at wadr and increment wadr.
    - If eod_in & ~err_in: wadr_cmt <= wadr+1 (commit).
    - If eod_in & err_in: wadr <= wadr_cmt (rewind), drop_pulse.
  - WR, overflow: we & full_flag rewinds wadr <= wadr_cmt and pulses drop_pulse. Go to DROP unless eod_in is set on that beat, in which case stay in WR.
  - DROP: ignore all writes; on we & eod_in return to WR. No second drop_pulse.
- Frames longer than DEPTH are therefore always dropped; the FIFO never deadlocks.
- Read accept = re & ~empty_flag; radr increments on accept.
- Read latency 1: rd_valid = registered accept; do/eod_out from RAM valid on the same cycle rd_valid is high.
- re while empty: ignored, rd_valid 0 next cycle.
- empty_flag and full_flag are combinational from the pointers.
- afull_flag and aempty_flag are registered (1-cycle lag).
- A commit and a read in the same cycle are both honoured; empty_flag deasserts the cycle after the commit edge.
- pkt_cnt: +1 on commit, -1 on rd_valid & eod_out; simultaneous events give net 0. Saturation never needed because pkt_cnt ≤ DEPTH.
- Rewind never moves wadr below wadr_cmt; reads never pass wadr_cmt.
- Reset mid-frame: all state cleared, any partial frame lost, no drop_pulse.

Optional Feature:
- Macro PKT_FIFO_STATS_EN.
- Defined: adds outputs good_frames[31:0] and dropped_frames[31:0].
  - Free-running, wrap at 2**32, reset to 0.
  - good_frames increments on commit; dropped_frames increments on drop_pulse.
- Undefined: ports and counters absent; all other behaviour identical.

Decomposition:
- Package pkt_fifo_pkg:
  - write FSM state enum {WR, DROP}.
  - occupancy function (modulo pointer difference).
  - default DW/AW constants.
- Sub-module sdp_ram: simple dual-port RAM, width DW+1, depth 2**AW, synchronous write and registered read on clkw. Infers block RAM.
- FSM, pointers and flags stay in the top-level module.

Test Plan:
- Write one 64-beat good frame (eod_in on beat 64), then read. Check:
  - empty_flag stays 1 until the commit edge.
  - pkt_cnt goes 0→1→0.
  - 64 rd_valid beats with data in order; eod_out only on the last beat.
- Write a 10-beat frame ending with eod_in=1, err_in=1. Check:
  - drop_pulse=1 for one cycle.
  - wadr returns to its pre-frame value; empty_flag stays 1 and pkt_cnt stays 0.
- With AW=4, write a 20-beat frame. Check:
  - full_flag asserts at 16 beats, then drop_pulse.
  - DROP state persists until eod_in; FIFO returns to empty.
  - A following 5-beat good frame reads back intact.
- Commit on the same cycle pkt_cnt decrements (last eod_out read) → pkt_cnt unchanged; no flag glitch.
- Pointer wrap: stream 3×DEPTH words in 100-beat frames with concurrent reads. Check no data corruption and flags correct across the wrap-bit toggle.
- Assert rst mid-frame and mid-read. All outputs return to reset values immediately, asynchronously.
- Stats build only: PKT_FIFO_STATS_EN defined, 3 good and 2 bad frames → good_frames=3, dropped_frames=2.
